// File: rtl/avl_sram16_ctrl.sv
// avl_sram16_ctrl: Avalon-MM slave that serves each 32-bit access as up to two 16-bit async SRAM half-cycles.
// Optional macro SRAM_TURNAROUND_EN inserts a one-cycle TURN state (bus idle) between DONE and IDLE.
module avl_sram16_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writedata,
  input  logic [3:0]            byteenable,
  input  logic                  read,
  input  logic                  write,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  waitrequest,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic [15:0]           sram_dq_o,
  input  logic [15:0]           sram_dq_i,
  output logic                  sram_dq_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned WA_W  = SRAM_AW - 1;

  if (DATA_WIDTH != 32) begin : g_bad_dw
    $error("avl_sram16_ctrl: DATA_WIDTH must be 32");
  end
  if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_ws
    $error("avl_sram16_ctrl: WAIT_STATES must be in 1..15");
  end

`ifdef SRAM_TURNAROUND_EN
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_LO, S_HI, S_DONE, S_TURN} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LO, S_HI, S_DONE} state_e;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WA_W-1:0]       waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic last_cyc;
  logic hi_half;
  logic req;
  logic unused_addr_bits;

  assign last_cyc = (cnt_q == CNT_W'(WAIT_STATES));
  assign hi_half  = (state_q == S_HI);
  assign req      = read | write;
  assign readdata = rdata_q;
  // Byte-offset and above-SRAM address bits carry no meaning for a 16-bit device.
  assign unused_addr_bits = ^{address[ADDR_WIDTH-1:SRAM_AW+1], address[1:0]};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Transaction datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      acc_q   <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    acc_d   = acc_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          waddr_d = address[SRAM_AW:2];
          wdata_d = writedata;
          be_d    = byteenable;
          wr_d    = write;
          cnt_d   = '0;
          if (!write) acc_d = '0;
          if (|byteenable[1:0])      state_d = S_LO;
          else if (|byteenable[3:2]) state_d = S_HI;
          else                       state_d = S_DONE;
        end
      end
      S_LO: begin
        if (last_cyc) begin
          if (!wr_q) acc_d[15:0] = sram_dq_i;
          cnt_d   = '0;
          state_d = (|be_q[3:2]) ? S_HI : S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HI: begin
        if (last_cyc) begin
          if (!wr_q) acc_d[31:16] = sram_dq_i;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef SRAM_TURNAROUND_EN
      S_DONE: state_d = S_TURN;
      S_TURN: state_d = S_IDLE;
`else
      S_DONE: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
    // Load readdata on entry to DONE so it is valid in the cycle waitrequest drops.
    if (state_d == S_DONE && !wr_d) rdata_d = acc_d;
  end

  // Avalon handshake and SRAM pin decode
  always_comb begin
    waitrequest = 1'b0;
    sram_addr   = '0;
    sram_dq_o   = '0;
    sram_dq_oe  = 1'b0;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_ub_n   = 1'b1;
    sram_lb_n   = 1'b1;
    unique case (state_q)
      S_IDLE: waitrequest = req;
      S_LO, S_HI: begin
        waitrequest = 1'b1;
        sram_ce_n   = 1'b0;
        sram_addr   = {waddr_q, hi_half};
        sram_lb_n   = hi_half ? ~be_q[2] : ~be_q[0];
        sram_ub_n   = hi_half ? ~be_q[3] : ~be_q[1];
        if (wr_q) begin
          sram_dq_oe = 1'b1;
          sram_dq_o  = hi_half ? wdata_q[31:16] : wdata_q[15:0];
          // Release WE on the final cycle so address and data are held past the write edge.
          sram_we_n  = last_cyc;
        end else begin
          sram_oe_n = 1'b0;
        end
      end
`ifdef SRAM_TURNAROUND_EN
      S_TURN: waitrequest = req;
`endif
      default: waitrequest = 1'b0;
    endcase
  end

endmodule
